// File: rtl/noc_credit_link_tx.sv
`default_nettype none
// ============================================================================
// Module  : noc_credit_link_tx
// Purpose : Credit-counting transmit end of a router link with wormhole
//           dest locking across the flits of a packet.
// Rev     : 1.0  initial release
// ============================================================================
module noc_credit_link_tx #(
    parameter int FLIT_WIDTH        = 32,
    parameter int DEST_WIDTH        = 4,
    parameter int FLIT_BUFFER_DEPTH = 8,
    parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                    clk_noc,
    input  logic                    rst_noc_sync,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [FLIT_WIDTH-1:0]   in_data,
    input  logic [DEST_WIDTH-1:0]   in_dest,
    input  logic                    in_last,
    output logic [FLIT_WIDTH-1:0]   data_out,
    output logic [DEST_WIDTH-1:0]   dest_out,
    output logic                    is_tail_out,
    output logic                    send_out,
    input  logic                    credit_in,
    output logic [CREDIT_WIDTH-1:0] credits_avail,
    output logic                    pkt_active,
    output logic                    credit_overflow
);

    localparam logic [CREDIT_WIDTH-1:0] c_DEPTH = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
    localparam logic [CREDIT_WIDTH-1:0] c_ONE   = CREDIT_WIDTH'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BODY = 1'b1
    } state_t;

    state_t                  r_state;
    logic [CREDIT_WIDTH-1:0] r_credits;
    logic [DEST_WIDTH-1:0]   r_pkt_dest;
    logic [FLIT_WIDTH-1:0]   r_data;
    logic [DEST_WIDTH-1:0]   r_dest;
    logic                    r_tail;
    logic                    r_send;
    logic                    r_overflow;

    logic                    w_ready;
    logic                    w_fire;
    logic                    w_credit_ovf;
    logic [CREDIT_WIDTH-1:0] w_credits_next;

    assign w_ready = (r_credits != '0);
    assign w_fire  = in_valid & w_ready;

    // A returned credit with nothing consumed while already full has no
    // buffer slot behind it: saturate and flag it instead of wrapping.
    assign w_credit_ovf = credit_in & ~w_fire & (r_credits == c_DEPTH);

    always_comb begin
        w_credits_next = r_credits;
        if (w_fire && !credit_in) begin
            w_credits_next = r_credits - c_ONE;
        end else if (!w_fire && credit_in && !w_credit_ovf) begin
            w_credits_next = r_credits + c_ONE;
        end
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            r_state    <= S_IDLE;
            r_credits  <= c_DEPTH;
            r_pkt_dest <= '0;
            r_data     <= '0;
            r_dest     <= '0;
            r_tail     <= 1'b0;
            r_send     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_credits <= w_credits_next;
            r_send    <= w_fire;
            if (w_credit_ovf) begin
                r_overflow <= 1'b1;
            end
            if (w_fire) begin
                r_data <= in_data;
                r_tail <= in_last;
                case (r_state)
                    S_IDLE: begin
                        r_dest <= in_dest;
                        if (!in_last) begin
                            r_state    <= S_BODY;
                            r_pkt_dest <= in_dest;
                        end
                    end
                    S_BODY: begin
                        // Body and tail flits follow the head's route.
                        r_dest <= r_pkt_dest;
                        if (in_last) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign in_ready        = w_ready;
    assign data_out        = r_data;
    assign dest_out        = r_dest;
    assign is_tail_out     = r_tail;
    assign send_out        = r_send;
    assign credits_avail   = r_credits;
    assign pkt_active      = (r_state == S_BODY);
    assign credit_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_noc_credit_link_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_noc_credit_link_tx
// Purpose : Scenario bench for noc_credit_link_tx with a flit scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
module tb_noc_credit_link_tx;

    localparam int FW = 32;
    localparam int DW = 4;
    localparam int CW = 4;

    logic          clk_noc = 1'b0;
    logic          rst_noc_sync = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [FW-1:0] in_data = '0;
    logic [DW-1:0] in_dest = '0;
    logic          in_last = 1'b0;
    logic [FW-1:0] data_out;
    logic [DW-1:0] dest_out;
    logic          is_tail_out;
    logic          send_out;
    logic          credit_in = 1'b0;
    logic [CW-1:0] credits_avail;
    logic          pkt_active;
    logic          credit_overflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [FW+DW:0] sb[$];
    logic           mon_en = 1'b0;
    logic           prev_fire = 1'b0;
    logic           m_body = 1'b0;
    logic [DW-1:0]  m_pkt_dest = '0;

    noc_credit_link_tx #(
        .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .FLIT_BUFFER_DEPTH(8), .CREDIT_WIDTH(CW)
    ) dut (
        .clk_noc(clk_noc), .rst_noc_sync(rst_noc_sync),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_dest(in_dest), .in_last(in_last),
        .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
        .send_out(send_out), .credit_in(credit_in), .credits_avail(credits_avail),
        .pkt_active(pkt_active), .credit_overflow(credit_overflow)
    );

    always #5 clk_noc = ~clk_noc;

    // Scoreboard: flits accepted before edge t must appear on the link in cycle t+1.
    always @(negedge clk_noc) begin
        if (mon_en) begin
            logic [FW+DW:0] exp_flit;
            logic [DW-1:0]  exp_dest;
            n_cmp++;
            if (send_out !== prev_fire) begin
                n_err++;
                $display("FAIL send_latency: send_out=%b expected %b at %0t", send_out, prev_fire, $time);
            end
            if (send_out === 1'b1) begin
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: flit %h with empty scoreboard", {data_out, dest_out, is_tail_out});
                end else begin
                    exp_flit = sb.pop_front();
                    n_cmp++;
                    if ({data_out, dest_out, is_tail_out} !== exp_flit) begin
                        n_err++;
                        $display("FAIL sb_flit: got data=%h dest=%h tail=%b expected data=%h dest=%h tail=%b",
                                 data_out, dest_out, is_tail_out,
                                 exp_flit[FW+DW:DW+1], exp_flit[DW:1], exp_flit[0]);
                    end
                end
            end
            if (rst_noc_sync) begin
                prev_fire = 1'b0;
                m_body    = 1'b0;
                sb.delete();
            end else begin
                prev_fire = in_valid & (credits_avail != 0);
                if (prev_fire) begin
                    if (m_body) begin
                        exp_dest = m_pkt_dest;
                        if (in_last) m_body = 1'b0;
                    end else begin
                        exp_dest = in_dest;
                        if (!in_last) begin
                            m_body     = 1'b1;
                            m_pkt_dest = in_dest;
                        end
                    end
                    sb.push_back({in_data, exp_dest, in_last});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_noc);
        #1;
    endtask

    task automatic return_credits(input int n);
        credit_in = 1'b1;
        repeat (n) step();
        credit_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_noc_sync = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        rst_noc_sync = 1'b0;
        n_cmp++;
        if (credits_avail !== 4'd8 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_credits: credits=%0d ready=%b expected 8/1", credits_avail, in_ready);
        end
        n_cmp++;
        if ({send_out, data_out, dest_out, is_tail_out, pkt_active, credit_overflow} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: send=%b data=%h dest=%h tail=%b act=%b ovf=%b expected all 0",
                     send_out, data_out, dest_out, is_tail_out, pkt_active, credit_overflow);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_burst();
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = FW'(i);
            in_dest = DW'(i);
            step();
        end
        in_data = 32'd8;
        in_dest = 4'h8;
        n_cmp++;
        if (credits_avail !== 4'd0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL burst_empty: credits=%0d ready=%b expected 0/0", credits_avail, in_ready);
        end
        step();
        step();
        n_cmp++;
        if (send_out !== 1'b0) begin
            n_err++;
            $display("FAIL burst_stall: send_out=%b expected 0", send_out);
        end
        credit_in = 1'b1;
        step();
        credit_in = 1'b0;
        n_cmp++;
        if (credits_avail !== 4'd1 || in_ready !== 1'b1 || send_out !== 1'b0) begin
            n_err++;
            $display("FAIL burst_credit: credits=%0d ready=%b send=%b expected 1/1/0",
                     credits_avail, in_ready, send_out);
        end
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (send_out !== 1'b1 || data_out !== 32'd8 || credits_avail !== 4'd0) begin
            n_err++;
            $display("FAIL burst_ninth: send=%b data=%0d credits=%0d expected 1/8/0",
                     send_out, data_out, credits_avail);
        end
    endtask

    task automatic test_back_to_back();
        return_credits(3);
        n_cmp++;
        if (credits_avail !== 4'd3) begin
            n_err++;
            $display("FAIL b2b_start: credits=%0d expected 3", credits_avail);
        end
        in_valid  = 1'b1;
        in_last   = 1'b1;
        credit_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 32'h100 + FW'(i);
            in_dest = DW'(i + 2);
            step();
            n_cmp++;
            if (credits_avail !== 4'd3 || send_out !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_hold: cycle %0d credits=%0d send=%b expected 3/1", i, credits_avail, send_out);
            end
        end
        in_valid  = 1'b0;
        credit_in = 1'b0;
        return_credits(5);
        n_cmp++;
        if (credits_avail !== 4'd8) begin
            n_err++;
            $display("FAIL b2b_refill: credits=%0d expected 8", credits_avail);
        end
    endtask

    task automatic test_wormhole();
        logic [DW-1:0] dests[4] = '{4'h5, 4'hA, 4'h3, 4'hF};
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'hA000 + FW'(i);
            in_dest = dests[i];
            in_last = (i == 3);
            step();
            n_cmp++;
            if (dest_out !== 4'h5 || is_tail_out !== (i == 3) || pkt_active !== (i != 3)) begin
                n_err++;
                $display("FAIL worm_flit%0d: dest=%h tail=%b act=%b expected 5/%b/%b",
                         i, dest_out, is_tail_out, pkt_active, (i == 3), (i != 3));
            end
        end
        in_data = 32'hB000;
        in_dest = 4'hA;
        in_last = 1'b1;
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (dest_out !== 4'hA || pkt_active !== 1'b0 || is_tail_out !== 1'b1) begin
            n_err++;
            $display("FAIL worm_next_head: dest=%h act=%b tail=%b expected A/0/1", dest_out, pkt_active, is_tail_out);
        end
        return_credits(5);
    endtask

    task automatic test_overflow();
        n_cmp++;
        if (credits_avail !== 4'd8 || credit_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_pre: credits=%0d ovf=%b expected 8/0", credits_avail, credit_overflow);
        end
        return_credits(1);
        n_cmp++;
        if (credits_avail !== 4'd8 || credit_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set: credits=%0d ovf=%b expected 8/1", credits_avail, credit_overflow);
        end
        repeat (3) step();
        n_cmp++;
        if (credit_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_sticky: ovf=%b expected 1", credit_overflow);
        end
    endtask

    task automatic test_midpacket_reset();
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_data  = 32'hC0;
        in_dest  = 4'h7;
        step();
        in_data  = 32'hC1;
        in_dest  = 4'h2;
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (credits_avail !== 4'd6 || pkt_active !== 1'b1 || dest_out !== 4'h7) begin
            n_err++;
            $display("FAIL rst_pre: credits=%0d act=%b dest=%h expected 6/1/7", credits_avail, pkt_active, dest_out);
        end
        rst_noc_sync = 1'b1;
        step();
        rst_noc_sync = 1'b0;
        n_cmp++;
        if (credits_avail !== 4'd8 || pkt_active !== 1'b0 || send_out !== 1'b0 || credit_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid: credits=%0d act=%b send=%b ovf=%b expected 8/0/0/0",
                     credits_avail, pkt_active, send_out, credit_overflow);
        end
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = 32'hD0;
        in_dest  = 4'h9;
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (dest_out !== 4'h9 || send_out !== 1'b1 || pkt_active !== 1'b0) begin
            n_err++;
            $display("FAIL rst_new_head: dest=%h send=%b act=%b expected 9/1/0", dest_out, send_out, pkt_active);
        end
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_burst();
        test_back_to_back();
        test_wormhole();
        test_overflow();
        test_midpacket_reset();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d flits never sent, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
